// File: rtl/matmul_loader.sv
// Serial loader for the 3x3 matrix multiplier: assembles A then B (row-major), fires the trigger and waits for completion.
// Optional build macro MATMUL_LOADER_KEEP_B_EN adds i_keep_b to reuse the previously loaded B.
module matmul_loader #(
    parameter int unsigned DATA_W       = 7,
    parameter int unsigned WAIT_TIMEOUT = 15
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [DATA_W-1:0]           i_data,
    input  logic                        i_valid,
    output logic                        o_accept,
    input  logic                        i_mm_ready,
`ifdef MATMUL_LOADER_KEEP_B_EN
    input  logic                        i_keep_b,
`endif
    output logic                        o_trigger,
    output logic [2:0][2:0][DATA_W-1:0] o_a,
    output logic [2:0][2:0][DATA_W-1:0] o_b,
    output logic                        o_done,
    output logic                        o_err
);

    localparam int unsigned K_W    = 4;
    localparam int unsigned LAST_K = 8;
    localparam int unsigned T_W    = $clog2(WAIT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        FIRE    = 3'd2,
        WAIT_LO = 3'd3,
        WAIT_HI = 3'd4
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [K_W-1:0]   k_q;
    logic [K_W-1:0]   k_d;
    logic [T_W-1:0]   tcnt_q;
    logic [T_W-1:0]   tcnt_d;
    logic             trigger_d;
    logic             done_d;
    logic             err_d;
    logic             wr_a;
    logic             wr_b;
    logic             keep_b;
    logic [1:0]       row;
    logic [1:0]       col;

`ifdef MATMUL_LOADER_KEEP_B_EN
    assign keep_b = i_keep_b;
`else
    assign keep_b = 1'b0;
`endif

    // Element index k -> [row][col] of the matrix being loaded
    always_comb begin
        row = 2'(k_q / K_W'(3));
        col = 2'(k_q % K_W'(3));
    end

    // Next-state, handshake and registered-output next values
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        tcnt_d    = tcnt_q;
        trigger_d = 1'b0;
        done_d    = 1'b0;
        err_d     = o_err;
        wr_a      = 1'b0;
        wr_b      = 1'b0;
        o_accept  = 1'b0;

        unique case (state_q)
            LOAD_A: begin
                o_accept = 1'b1;
                if (i_valid) begin
                    wr_a = 1'b1;
                    if (k_q == K_W'(LAST_K)) begin
                        k_d     = '0;
                        state_d = keep_b ? FIRE : LOAD_B;
                    end else begin
                        k_d = k_q + K_W'(1);
                    end
                end
            end
            LOAD_B: begin
                o_accept = 1'b1;
                if (i_valid) begin
                    wr_b = 1'b1;
                    if (k_q == K_W'(LAST_K)) begin
                        k_d     = '0;
                        state_d = FIRE;
                    end else begin
                        k_d = k_q + K_W'(1);
                    end
                end
            end
            FIRE: begin
                if (i_mm_ready) begin
                    trigger_d = 1'b1;
                    tcnt_d    = '0;
                    state_d   = WAIT_LO;
                end
            end
            WAIT_LO: begin
                // Multiplier must drop ready to show it took the job
                if (!i_mm_ready) begin
                    state_d = WAIT_HI;
                end else begin
                    tcnt_d = tcnt_q + T_W'(1);
                    if (tcnt_d == T_W'(WAIT_TIMEOUT)) begin
                        err_d   = 1'b1;
                        k_d     = '0;
                        state_d = LOAD_A;
                    end
                end
            end
            WAIT_HI: begin
                if (i_mm_ready) begin
                    done_d  = 1'b1;
                    k_d     = '0;
                    state_d = LOAD_A;
                end
            end
            default: begin
                k_d     = '0;
                state_d = LOAD_A;
            end
        endcase
    end

    // Control state and pulse outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= LOAD_A;
            k_q       <= '0;
            tcnt_q    <= '0;
            o_trigger <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            tcnt_q    <= tcnt_d;
            o_trigger <= trigger_d;
            o_done    <= done_d;
            o_err     <= err_d;
        end
    end

    // Matrix storage; elements persist across jobs until overwritten
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_a <= '0;
            o_b <= '0;
        end else begin
            if (wr_a) o_a[row][col] <= i_data;
            if (wr_b) o_b[row][col] <= i_data;
        end
    end

endmodule

// File: doc/matmul_loader.md
Name: matmul_loader

Overview:
- Upstream feeder for the 3x3 matrix multiplier.
- Accepts a serial stream of 7-bit elements over a valid/ready handshake and assembles matrix A, then matrix B, both in row-major order.
- Pulses the multiplier trigger once both matrices are complete and the multiplier reports ready, then waits for the multiplier's processing cycle to finish before reporting completion.

Parameters:
- DATA_W, 7, element width; must match the multiplier's element width.
- WAIT_TIMEOUT, 15, cycles allowed in WAIT_LO for the multiplier's ready to drop before flagging an error.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_data  input  DATA_W  stream element
- i_valid  input  1  i_data is valid
- o_accept  output  1  loader can take an element this cycle
- i_mm_ready  input  1  multiplier ready; connect to the multiplier's o_ready
- o_trigger  output  1  one-cycle start pulse to the multiplier's i_trigger
- o_a  output  DATA_W x [3][3]  assembled matrix A, [row][col]
- o_b  output  DATA_W x [3][3]  assembled matrix B, [row][col]
- o_done  output  1  one-cycle pulse: multiplier cycle complete, result valid
- o_err  output  1  sticky timeout flag; cleared by i_rst only

Behaviour:
- One clock: i_clk. Reset is synchronous, active-high: i_rst.
- Reset values:
  - state = LOAD_A, element counter = 0, timeout counter = 0.
  - All o_a and o_b elements = 0.
  - o_trigger = 0, o_done = 0, o_err = 0.
- i_rst wins over every other event, including mid-load and during WAIT_*.
- o_accept is combinational: 1 only in LOAD_A and LOAD_B.
- A transfer happens when i_valid && o_accept at the rising edge. i_data is ignored otherwise.
- Element index k (0..8) maps to row = k/3, col = k%3.
- States:
  - LOAD_A: each transfer writes o_a[k/3][k%3] and increments k. The transfer at k = 8 resets k to 0 and moves to LOAD_B.
  - LOAD_B: same, writing o_b. The transfer at k = 8 moves to FIRE.
  - FIRE: o_accept = 0. If i_mm_ready is high, register o_trigger = 1 for exactly one cycle and move to WAIT_LO, clearing the timeout counter. Otherwise stay in FIRE indefinitely with o_trigger = 0.
  - WAIT_LO: o_trigger = 0. Leave when i_mm_ready = 0, going to WAIT_HI.
    - The timeout counter increments each cycle spent here.
    - If it reaches WAIT_TIMEOUT, set o_err = 1 and go to LOAD_A with k = 0. o_done is not pulsed.
  - WAIT_HI: when i_mm_ready = 1, pulse o_done for one cycle and go to LOAD_A with k = 0.
- Latency:
  - Trigger pulse: one cycle after entering FIRE with i_mm_ready high.
  - o_done: asserted the cycle after the multiplier's ready returns high, at the earliest 3 cycles after the trigger pulse.
- o_a and o_b are not cleared between jobs. Each element holds its value until overwritten by the next load. The multiplier latches its inputs on the trigger, so overwriting during WAIT_* is harmless.
- o_done and o_trigger are never high in the same cycle.
- The bench drives i_valid only; back-pressure comes solely from o_accept.

Optional Feature:
- Macro: MATMUL_LOADER_KEEP_B_EN.
- When defined:
  - Adds port i_keep_b (input, 1 bit).
  - i_keep_b is sampled on the transfer that completes A (k = 8 in LOAD_A).
  - If it is 1, skip LOAD_B and go directly to FIRE; o_b retains the previous matrix. This covers reuse of a constant B.
- When undefined: no i_keep_b port; LOAD_B is always traversed.

Test Plan:
- Reset then stream A = 1..9 and B = identity, with i_mm_ready held high:
  - o_a[1][2] = 6, o_b[2][2] = 1.
  - o_trigger pulses once, one cycle after the 18th transfer.
  - With the real multiplier attached, o_done pulses and its result equals A.
- i_valid toggled every other cycle:
  - Exactly 18 transfers are accepted.
  - o_accept = 0 from FIRE until after o_done.
- i_mm_ready held low on entry to FIRE for 5 cycles:
  - No trigger pulse while low.
  - Trigger pulses the cycle after i_mm_ready rises.
- i_mm_ready never drops after the trigger:
  - o_err = 1 exactly WAIT_TIMEOUT = 15 cycles after the trigger pulse.
  - o_done never pulses; the next stream loads normally.
- Assert i_rst after 4 A elements:
  - All outputs return to reset values.
  - The next element is written to o_a[0][0].
- With MATMUL_LOADER_KEEP_B_EN defined: load A and B, then a second A with i_keep_b = 1:
  - Second job fires after only 9 transfers.
  - o_b is unchanged.
